// File: rtl/ysyx_22041412_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, branch func3 codes,
// error codes and the default reset PC.
package ysyx_22041412_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMulw   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    localparam logic [1:0] ErrNone  = 2'd0;
    localparam logic [1:0] ErrImem  = 2'd1;
    localparam logic [1:0] ErrWait  = 2'd2;
    localparam logic [1:0] ErrAlign = 2'd3;

    localparam logic [63:0] DefaultResetPc = 64'h0000_0000_8000_0000;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22041412_br_cmp.sv
// Branch resolution and next-PC selection; purely combinational.
module ysyx_22041412_br_cmp
    import ysyx_22041412_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [2:0]      func3,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] dnpc
);

    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            taken;
    logic [XLEN-1:0] jalr_sum;

    // Relational compares only; no subtract-and-test-sign path.
    assign eq   = rs1_val == rs2_val;
    assign lt_s = $signed(rs1_val) < $signed(rs2_val);
    assign lt_u = rs1_val < rs2_val;

    always_comb begin
        taken = 1'b0;
        case (func3)
            F3Beq:   taken = eq;
            F3Bne:   taken = ~eq;
            F3Blt:   taken = lt_s;
            F3Bge:   taken = ~lt_s;
            F3Bltu:  taken = lt_u;
            F3Bgeu:  taken = ~lt_u;
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum = rs1_val + imm;

    always_comb begin
        dnpc = pc + XLEN'(4);
        if (is_jalr) begin
            dnpc = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (is_jal || (is_branch && taken)) begin
            dnpc = pc + imm;
        end
    end

endmodule

// File: rtl/ysyx_22041412_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with handshake
// watchdog, misaligned-target trap and a sticky halt state.
module ysyx_22041412_seq_ctrl
    import ysyx_22041412_seq_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = DefaultResetPc[XLEN-1:0],
    parameter int unsigned     WAIT_W   = 8,
    parameter int unsigned     TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_inst,
    output logic [31:0]     ir,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            is_mul,
    input  logic            is_ebreak,
    input  logic            rd_wen,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            mul_start,
    input  logic            mul_done,
    output logic            reg_we,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] dnpc,
    output logic            commit,
    output logic            halted,
    output logic [1:0]      err
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        err_q, err_d;

    logic imem_req_c, dmem_req_c, dmem_we_c, mul_start_c, reg_we_c, commit_c;
    logic wait_hit;

    ysyx_22041412_br_cmp #(
        .XLEN(XLEN)
    ) u_br_cmp (
        .func3    (func3),
        .is_branch(is_branch),
        .is_jal   (is_jal),
        .is_jalr  (is_jalr),
        .pc       (pc_q),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .imm      (imm),
        .dnpc     (dnpc)
    );

    // Final wait cycle: a handshake landing here still completes normally.
    assign wait_hit = wait_q == WAIT_W'(TIMEOUT - 1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        wait_d      = wait_q;
        err_d       = err_q;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        mul_start_c = 1'b0;
        reg_we_c    = 1'b0;
        commit_c    = 1'b0;

        case (state_q)
            StFetch: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_inst;
                    state_d = StDecode;
                end else if (wait_hit) begin
                    err_d   = ErrImem;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                if (is_ebreak) begin
                    commit_c = 1'b1;
                    err_d    = ErrNone;
                    state_d  = StHalt;
                end else if (is_mul) begin
                    mul_start_c = 1'b1;
                    wait_d      = '0;
                    state_d     = StMulw;
                end else if (is_load || is_store) begin
                    wait_d  = '0;
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMulw: begin
                if (mul_done) begin
                    state_d = StWb;
                end else if (wait_hit) begin
                    err_d   = ErrWait;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StMem: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_store;
                if (dmem_ready) begin
                    state_d = StWb;
                end else if (wait_hit) begin
                    err_d   = ErrWait;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StWb: begin
                // A misaligned target traps without retiring or writing rd.
                if (is_misaligned(dnpc[1:0])) begin
                    err_d   = ErrAlign;
                    state_d = StHalt;
                end else begin
                    reg_we_c = rd_wen & ~is_store & ~is_branch;
                    commit_c = 1'b1;
                    pc_d     = dnpc;
                    wait_d   = '0;
                    state_d  = StFetch;
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            wait_q  <= '0;
            err_q   <= ErrNone;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Requests and pulses are dropped while reset is held.
    assign imem_req  = imem_req_c & ~rst;
    assign dmem_req  = dmem_req_c & ~rst;
    assign dmem_we   = dmem_we_c & ~rst;
    assign mul_start = mul_start_c & ~rst;
    assign reg_we    = reg_we_c & ~rst;
    assign commit    = commit_c & ~rst;

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign halted    = state_q == StHalt;
    assign err       = err_q;

endmodule

// File: tb/tb_ysyx_22041412_seq_ctrl.sv
// Directed bench for the sequencer: a next-PC vector table plus multi-cycle
// handshake, watchdog, trap and reset sequences.
module tb_ysyx_22041412_seq_ctrl;

    localparam logic [63:0] RPC  = 64'h0000_0000_8000_0000;
    localparam logic [31:0] ADDI = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ready = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_inst = '0, ir;
    logic        is_branch = 0, is_jal = 0, is_jalr = 0, is_load = 0;
    logic        is_store = 0, is_mul = 0, is_ebreak = 0, rd_wen = 0;
    logic [2:0]  func3 = '0;
    logic [63:0] rs1_val = '0, rs2_val = '0, imm = '0;
    logic        dmem_req, dmem_we, dmem_ready = 1'b0;
    logic        mul_start, mul_done = 1'b0;
    logic        reg_we, commit, halted;
    logic [63:0] pc, dnpc;
    logic [1:0]  err;

    int n_pass = 0;
    int n_total = 0;

    int r_commits, r_regwe, r_dreq, r_dwe, r_mstart, r_fcnt, r_mcnt, r_ccyc;
    logic r_done;

    ysyx_22041412_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ready(imem_ready),
        .imem_inst (imem_inst),
        .ir        (ir),
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_mul    (is_mul),
        .is_ebreak (is_ebreak),
        .rd_wen    (rd_wen),
        .func3     (func3),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .imm       (imm),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ready(dmem_ready),
        .mul_start (mul_start),
        .mul_done  (mul_done),
        .reg_we    (reg_we),
        .pc        (pc),
        .dnpc      (dnpc),
        .commit    (commit),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] im;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_dec(input logic br, jal, jalr, ld, st, mul, eb, rdw,
                           input logic [2:0] f, input logic [63:0] a, b, im);
        is_branch = br; is_jal = jal; is_jalr = jalr; is_load = ld;
        is_store = st; is_mul = mul; is_ebreak = eb; rd_wen = rdw;
        func3 = f; rs1_val = a; rs2_val = b; imm = im;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0; mul_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one instruction from FETCH. Handshakes answer on the (wait+1)th
    // requesting cycle; mwait < 0 means the multiplier never finishes.
    task automatic run_instr(input int fwait, input logic [31:0] inst, input int mwait);
        bit mul_act;
        bit was_commit;
        r_commits = 0; r_regwe = 0; r_dreq = 0; r_dwe = 0; r_mstart = 0;
        r_fcnt = 0; r_mcnt = 0; r_ccyc = -1; r_done = 1'b0;
        mul_act = 1'b0;
        for (int c = 0; c < 700; c++) begin
            #1;
            if (halted) begin
                r_done = 1'b1;
                break;
            end
            imem_inst  = inst;
            imem_ready = imem_req && (r_fcnt == fwait);
            dmem_ready = dmem_req && (r_mcnt == mwait);
            mul_done   = mul_act && (r_mcnt == mwait);
            #1;
            if (commit) begin
                r_commits++;
                r_ccyc = c;
            end
            if (reg_we) r_regwe++;
            if (dmem_req) begin
                r_dreq++;
                if (dmem_we) r_dwe++;
            end
            if (imem_req) r_fcnt++;
            if (dmem_req || mul_act) r_mcnt++;
            if (mul_done) mul_act = 1'b0;
            if (mul_start) begin
                r_mstart++;
                mul_act = 1'b1;
            end
            was_commit = commit;
            @(negedge clk);
            imem_ready = 1'b0; dmem_ready = 1'b0; mul_done = 1'b0;
            if (was_commit) begin
                r_done = 1'b1;
                break;
            end
        end
        chk("instr_done", {63'd0, r_done}, 64'd1);
        #1;
    endtask

    initial begin
        int cmt;
        int dreq;

        // pc = 0x80000010 for every vector.
        vecs[0]  = '{3'b000, 1, 0, 0, 64'd5, 64'd5, -64'sd16, 64'h8000_0000};
        vecs[1]  = '{3'b000, 1, 0, 0, 64'd5, 64'd6, -64'sd16, 64'h8000_0014};
        vecs[2]  = '{3'b001, 1, 0, 0, 64'd5, 64'd6, -64'sd16, 64'h8000_0000};
        vecs[3]  = '{3'b100, 1, 0, 0, '1, 64'd1, -64'sd16, 64'h8000_0000};
        vecs[4]  = '{3'b101, 1, 0, 0, '1, 64'd1, -64'sd16, 64'h8000_0014};
        vecs[5]  = '{3'b110, 1, 0, 0, '1, 64'd1, -64'sd16, 64'h8000_0014};
        vecs[6]  = '{3'b111, 1, 0, 0, '1, 64'd1, -64'sd16, 64'h8000_0000};
        vecs[7]  = '{3'b100, 1, 0, 0, 64'd1, '1, -64'sd16, 64'h8000_0014};
        vecs[8]  = '{3'b010, 1, 0, 0, 64'd7, 64'd7, -64'sd16, 64'h8000_0014};
        vecs[9]  = '{3'b011, 1, 0, 0, 64'd7, 64'd9, -64'sd16, 64'h8000_0014};
        vecs[10] = '{3'b000, 0, 0, 0, 64'd7, 64'd7, -64'sd16, 64'h8000_0014};
        vecs[11] = '{3'b000, 0, 1, 0, 64'd0, 64'd0, 64'h100, 64'h8000_0110};
        vecs[12] = '{3'b000, 0, 0, 1, 64'h8000_1001, 64'd0, 64'd0, 64'h8000_1000};
        vecs[13] = '{3'b000, 0, 0, 1, 64'h8000_1000, 64'd0, '1, 64'h8000_0ffe};
        vecs[14] = '{3'b000, 0, 1, 0, 64'd0, 64'd0, 64'hffff_ffff_8000_0000, 64'h10};

        // Reset state, observed while reset is still held.
        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_pc", pc, RPC);
        chk("rst_ir", {32'd0, ir}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_err", {62'd0, err}, 64'd0);
        chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("fetch_req", {63'd0, imem_req}, 64'd1);
        chk("fetch_addr", imem_addr, RPC);

        // First addi with fetch ready on the fourth request cycle.
        set_dec(0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 64'd0, 64'd0, 64'd0);
        run_instr(3, ADDI, 0);
        chk("addi_commits", 64'(r_commits), 64'd1);
        chk("addi_regwe", 64'(r_regwe), 64'd1);
        chk("addi_commit_cycle", 64'(r_ccyc), 64'd6);
        chk("addi_pc", pc, 64'h8000_0004);
        chk("addi_ir", {32'd0, ir}, {32'd0, ADDI});

        for (int i = 0; i < 3; i++) run_instr(0, ADDI, 0);
        chk("pc_after_4", pc, 64'h8000_0010);

        for (int i = 0; i < 15; i++) begin
            set_dec(vecs[i].br, vecs[i].jal, vecs[i].jalr, 0, 0, 0, 0, 0,
                    vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].im);
            #1;
            chk($sformatf("dnpc_vec%0d", i), dnpc, vecs[i].exp);
            @(negedge clk);
        end

        // Taken beq retires without writing rd.
        set_dec(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 64'd3, 64'd3, -64'sd16);
        run_instr(0, 32'h0000_0063, 0);
        chk("beq_commits", 64'(r_commits), 64'd1);
        chk("beq_regwe", 64'(r_regwe), 64'd0);
        chk("beq_pc", pc, 64'h8000_0000);

        set_dec(0, 0, 0, 1, 0, 0, 0, 1, 3'b011, 64'd0, 64'd0, 64'd0);
        run_instr(1, 32'h0000_3003, 9);
        chk("load_dreq_cycles", 64'(r_dreq), 64'd10);
        chk("load_dwe", 64'(r_dwe), 64'd0);
        chk("load_regwe", 64'(r_regwe), 64'd1);
        chk("load_pc", pc, 64'h8000_0004);

        set_dec(0, 0, 0, 0, 1, 0, 0, 1, 3'b011, 64'd0, 64'd0, 64'd0);
        run_instr(0, 32'h0000_3023, 2);
        chk("store_dreq_cycles", 64'(r_dreq), 64'd3);
        chk("store_dwe", 64'(r_dwe), 64'd3);
        chk("store_regwe", 64'(r_regwe), 64'd0);
        chk("store_pc", pc, 64'h8000_0008);

        set_dec(0, 0, 0, 0, 0, 1, 0, 1, 3'b000, 64'd0, 64'd0, 64'd0);
        run_instr(0, 32'h0200_0033, 4);
        chk("mul_starts", 64'(r_mstart), 64'd1);
        chk("mul_regwe", 64'(r_regwe), 64'd1);
        chk("mul_pc", pc, 64'h8000_000c);

        set_dec(0, 0, 1, 0, 0, 0, 0, 1, 3'b000, 64'h8000_1001, 64'd0, 64'd0);
        run_instr(0, 32'h0000_0067, 0);
        chk("jalr_pc", pc, 64'h8000_1000);

        // Misaligned jal target traps with pc frozen.
        set_dec(0, 1, 0, 0, 0, 0, 0, 1, 3'b000, 64'd0, 64'd0, 64'd2);
        run_instr(0, 32'h0000_006f, 0);
        chk("jal_mis_commits", 64'(r_commits), 64'd0);
        chk("jal_mis_halted", {63'd0, halted}, 64'd1);
        chk("jal_mis_err", {62'd0, err}, 64'd3);
        repeat (3) @(negedge clk);
        #1;
        chk("halt_pc_frozen", pc, 64'h8000_1000);
        chk("halt_no_req", {63'd0, imem_req}, 64'd0);

        do_reset();
        set_dec(0, 0, 0, 0, 0, 0, 1, 0, 3'b000, 64'd0, 64'd0, 64'd0);
        run_instr(0, 32'h0010_0073, 0);
        chk("ebreak_commits", 64'(r_commits), 64'd1);
        chk("ebreak_cycle", 64'(r_ccyc), 64'd2);
        chk("ebreak_halted", {63'd0, halted}, 64'd1);
        chk("ebreak_err", {62'd0, err}, 64'd0);
        chk("ebreak_pc", pc, RPC);

        // Fetch ready on the last allowed cycle still completes.
        do_reset();
        set_dec(0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 64'd0, 64'd0, 64'd0);
        run_instr(254, ADDI, 0);
        chk("wd_edge_commits", 64'(r_commits), 64'd1);
        chk("wd_edge_err", {62'd0, err}, 64'd0);
        chk("wd_edge_pc", pc, 64'h8000_0004);

        set_dec(0, 0, 0, 0, 0, 1, 0, 1, 3'b000, 64'd0, 64'd0, 64'd0);
        run_instr(0, 32'h0200_0033, -1);
        chk("wd_mul_cycles", 64'(r_mcnt), 64'd255);
        chk("wd_mul_halted", {63'd0, halted}, 64'd1);
        chk("wd_mul_err", {62'd0, err}, 64'd2);
        chk("wd_mul_commits", 64'(r_commits), 64'd0);

        do_reset();
        set_dec(0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 64'd0, 64'd0, 64'd0);
        run_instr(255, ADDI, 0);
        chk("wd_imem_cycles", 64'(r_fcnt), 64'd255);
        chk("wd_imem_halted", {63'd0, halted}, 64'd1);
        chk("wd_imem_err", {62'd0, err}, 64'd1);

        // Reset in the middle of a data access; a late ready is ignored.
        do_reset();
        set_dec(0, 0, 0, 1, 0, 0, 0, 1, 3'b011, 64'd0, 64'd0, 64'd0);
        #1;
        imem_ready = 1'b1;
        imem_inst  = 32'h0000_3003;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_mem_req", {63'd0, dmem_req}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rst_dreq", {63'd0, dmem_req}, 64'd0);
        chk("after_rst_ireq", {63'd0, imem_req}, 64'd1);
        chk("after_rst_pc", pc, RPC);
        dmem_ready = 1'b1;
        cmt = 0;
        dreq = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (commit) cmt++;
            if (dmem_req) dreq++;
        end
        dmem_ready = 1'b0;
        chk("late_ready_commit", 64'(cmt), 64'd0);
        chk("late_ready_dreq", 64'(dreq), 64'd0);
        chk("late_ready_fetch", {63'd0, imem_req}, 64'd1);
        chk("late_ready_pc", pc, RPC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
